// File: rtl/universal_register_if.sv
// universal_register_if: control, data and status bundle for one universal register
interface universal_register_if #(parameter int n = 8);
  logic         en;
  logic [2:0]   mode;
  logic [n-1:0] d;
  logic         sin;
  logic [n-1:0] q;
  logic         co;
  logic         zero;
  modport master(output en, mode, d, sin, input q, co, zero);
  modport slave(input en, mode, d, sin, output q, co, zero);
endinterface

// File: rtl/universal_register.sv
// universal_register: n-bit register with load, shift, rotate, increment and decrement modes
module universal_register #(
  parameter int           n       = 8,
  parameter logic [n-1:0] RST_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  universal_register_if.slave  bus
);
  typedef enum logic [2:0] {
    HOLD = 3'd0,
    LOAD = 3'd1,
    SHL  = 3'd2,
    SHR  = 3'd3,
    ROL  = 3'd4,
    ROR  = 3'd5,
    INC  = 3'd6,
    DEC  = 3'd7
  } mode_e;
  logic [n-1:0] q_q, q_d;
  logic         co_q, co_d;
  logic [n:0]   inc_w, dec_w;
  mode_e        mode_w;
  assign mode_w = mode_e'(bus.mode);
  assign inc_w  = {1'b0, q_q} + 1'b1;
  assign dec_w  = {1'b0, q_q} - 1'b1;
  // next state per mode; en low or HOLD keeps q and co, and the wide
  // inc/dec results deliver carry and borrow in their top bit
  always_comb begin
    q_d  = q_q;
    co_d = co_q;
    if (bus.en) begin
      case (mode_w)
        HOLD: ;
        LOAD: begin q_d = bus.d;                   co_d = 1'b0;      end
        SHL:  begin q_d = {q_q[n-2:0], bus.sin};   co_d = q_q[n-1];  end
        SHR:  begin q_d = {bus.sin, q_q[n-1:1]};   co_d = q_q[0];    end
        ROL:  begin q_d = {q_q[n-2:0], q_q[n-1]};  co_d = q_q[n-1];  end
        ROR:  begin q_d = {q_q[0], q_q[n-1:1]};    co_d = q_q[0];    end
        INC:  begin q_d = inc_w[n-1:0];            co_d = inc_w[n];  end
        DEC:  begin q_d = dec_w[n-1:0];            co_d = dec_w[n];  end
      endcase
    end
  end
  // state register; reset overrides enable and mode on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q  <= RST_VAL;
      co_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      co_q <= co_d;
    end
  end
  assign bus.q    = q_q;
  assign bus.co   = co_q;
  assign bus.zero = (q_q == '0);
endmodule

// File: tb/tb_universal_register.sv
// tb_universal_register: directed and random checks of three register configurations against a reference model
module tb_universal_register;
  logic clk = 1'b0;
  logic ra, rb, rc;
  int checks = 0;
  int errors = 0;
  universal_register_if #(.n(8)) ia ();
  universal_register_if #(.n(8)) ib ();
  universal_register_if #(.n(2)) ic ();
  universal_register #(.n(8), .RST_VAL(8'hA5)) dut_a (.clk(clk), .rst(ra), .bus(ia.slave));
  universal_register #(.n(8), .RST_VAL(8'h00)) dut_b (.clk(clk), .rst(rb), .bus(ib.slave));
  universal_register #(.n(2), .RST_VAL(2'b11)) dut_c (.clk(clk), .rst(rc), .bus(ic.slave));
  always #5 clk = ~clk;
  int              W [3] = '{8, 8, 2};
  longint unsigned RV[3] = '{64'hA5, 64'h00, 64'h3};
  longint unsigned mq[3];
  logic            mco[3];
  logic            r[3], e[3], s[3];
  logic [2:0]      m[3];
  longint unsigned dd[3];
  localparam logic [2:0] HOLD = 0, LOAD = 1, SHL = 2, SHR = 3, ROL = 4, ROR = 5, INC = 6, DEC = 7;
  task automatic chk(input string tag, input longint unsigned obs, input longint unsigned exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic longint unsigned oq(int i);
    return i == 0 ? 64'(ia.q) : i == 1 ? 64'(ib.q) : 64'(ic.q);
  endfunction
  function automatic logic oco(int i);
    return i == 0 ? ia.co : i == 1 ? ib.co : ic.co;
  endfunction
  function automatic logic oz(int i);
    return i == 0 ? ia.zero : i == 1 ? ib.zero : ic.zero;
  endfunction
  task automatic set(int i, logic rr, logic ee, logic [2:0] mm, longint unsigned dv, logic ss);
    r[i] = rr; e[i] = ee; m[i] = mm; dd[i] = dv; s[i] = ss;
  endtask
  task automatic idle();
    for (int i = 0; i < 3; i++) set(i, 0, 0, HOLD, 0, 0);
  endtask
  task automatic model(int i);
    longint unsigned mask, msb, lsb;
    mask = (64'd1 << W[i]) - 1;
    msb  = (mq[i] >> (W[i] - 1)) & 1;
    lsb  = mq[i] & 1;
    if (r[i]) begin
      mq[i] = RV[i]; mco[i] = 0;
    end else if (e[i]) begin
      case (m[i])
        LOAD: begin mq[i] = dd[i] & mask; mco[i] = 0; end
        SHL:  begin mco[i] = msb[0]; mq[i] = (mq[i] * 2 + 64'(s[i])) & mask; end
        SHR:  begin mco[i] = lsb[0]; mq[i] = (mq[i] / 2) + (64'(s[i]) << (W[i] - 1)); end
        ROL:  begin mco[i] = msb[0]; mq[i] = (mq[i] * 2 + msb) & mask; end
        ROR:  begin mco[i] = lsb[0]; mq[i] = (mq[i] / 2) + (lsb << (W[i] - 1)); end
        INC:  begin mco[i] = (mq[i] == mask); mq[i] = (mq[i] == mask) ? 0 : mq[i] + 1; end
        DEC:  begin mco[i] = (mq[i] == 0); mq[i] = (mq[i] == 0) ? mask : mq[i] - 1; end
        default: ;
      endcase
    end
  endtask
  task automatic step();
    ra = r[0]; rb = r[1]; rc = r[2];
    ia.en = e[0]; ia.mode = m[0]; ia.d = dd[0][7:0]; ia.sin = s[0];
    ib.en = e[1]; ib.mode = m[1]; ib.d = dd[1][7:0]; ib.sin = s[1];
    ic.en = e[2]; ic.mode = m[2]; ic.d = dd[2][1:0]; ic.sin = s[2];
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      model(i);
      chk($sformatf("model_q%0d", i), oq(i), mq[i]);
      chk($sformatf("model_co%0d", i), 64'(oco(i)), 64'(mco[i]));
      chk($sformatf("model_zero%0d", i), 64'(oz(i)), 64'(mq[i] == 0));
    end
  endtask
  task automatic expect_st(input string tag, int i, longint unsigned q, logic co);
    chk({tag, "_q"}, oq(i), q);
    chk({tag, "_co"}, 64'(oco(i)), 64'(co));
  endtask
  initial begin
    for (int i = 0; i < 3; i++) set(i, 1, 1, LOAD, 64'h3C, 0);
    step();
    step();
    expect_st("rst_a", 0, 64'hA5, 0);
    chk("rst_a_zero", 64'(ia.zero), 0);
    expect_st("rst_c", 2, 64'h3, 0);
    chk("rst_b_zero", 64'(ib.zero), 1);
    idle();
    set(0, 0, 1, LOAD, 64'h3C, 0); step(); expect_st("load_3c", 0, 64'h3C, 0);
    set(0, 0, 0, INC, 64'hFF, 1);  step(); expect_st("en0_inc", 0, 64'h3C, 0);
    set(0, 0, 0, SHL, 64'hFF, 1);  step(); expect_st("en0_shl", 0, 64'h3C, 0);
    set(0, 0, 0, LOAD, 64'hFF, 1); step(); expect_st("en0_load", 0, 64'h3C, 0);
    set(0, 0, 0, INC, 64'hFF, 1);  step(); expect_st("en0_inc2", 0, 64'h3C, 0);
    set(0, 0, 1, HOLD, 64'hFF, 1); step(); step(); expect_st("hold", 0, 64'h3C, 0);
    set(0, 0, 1, LOAD, 64'h81, 0); step();
    set(0, 0, 1, SHL, 0, 0); step(); expect_st("shl", 0, 64'h02, 1);
    set(0, 0, 1, SHR, 0, 1); step(); expect_st("shr", 0, 64'h81, 0);
    set(0, 0, 1, ROL, 0, 0); step(); expect_st("rol", 0, 64'h03, 1);
    set(0, 0, 1, ROR, 0, 0); step(); expect_st("ror", 0, 64'h81, 1);
    set(0, 0, 1, LOAD, 64'hFE, 0); step();
    set(0, 0, 1, INC, 0, 0); step(); expect_st("inc1", 0, 64'hFF, 0);
    step(); expect_st("inc2", 0, 64'h00, 1); chk("inc2_zero", 64'(ia.zero), 1);
    set(0, 0, 1, DEC, 0, 0); step(); expect_st("dec1", 0, 64'hFF, 1); chk("dec1_zero", 64'(ia.zero), 0);
    step(); expect_st("dec2", 0, 64'hFE, 0);
    idle();
    set(1, 0, 1, LOAD, 64'h10, 0); step();
    set(1, 0, 1, INC, 0, 0); step(); step(); step(); expect_st("cnt13", 1, 64'h13, 0);
    set(1, 1, 1, INC, 0, 0); step(); expect_st("rst_mid", 1, 64'h00, 0); chk("rst_mid_zero", 64'(ib.zero), 1);
    set(1, 0, 1, INC, 0, 0); step(); expect_st("post_rst_inc", 1, 64'h01, 0);
    idle();
    set(2, 1, 1, INC, 0, 0); step(); expect_st("n2_rst", 2, 64'h3, 0);
    set(2, 0, 1, INC, 0, 0); step(); expect_st("n2_inc", 2, 64'h0, 1);
    set(2, 0, 1, DEC, 0, 0); step(); expect_st("n2_dec", 2, 64'h3, 1);
    set(2, 0, 1, LOAD, 64'h2, 0); step();
    set(2, 0, 1, ROL, 0, 0); step(); expect_st("n2_rol", 2, 64'h1, 1);
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 3; i++)
        set(i, $urandom_range(15) == 0, $urandom_range(3) != 0, 3'($urandom_range(7)),
            {32'($urandom), 32'($urandom)}, 1'($urandom_range(1)));
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/universal_register.md
Name: universal_register

Overview:
- Parametrised successor to the team's plain N-bit D register.
- Adds synchronous reset with a programmable reset value, a clock enable, and an 8-mode operation select: hold, parallel load, logical shift left/right with serial input, rotate left/right, increment and decrement.
- Drives a registered carry/shift-out flag and a combinational zero flag.
- Sits in the lab datapath as a general-purpose accumulator, shift register or counter element, replacing ad-hoc registers.

Parameters:
- n, 8: register width in bits; legal range 2..64.
- RST_VAL, 0: value loaded into q on reset; n bits wide.

Ports:
- clk  input  1  rising-edge clock; all state changes on posedge clk.
- rst  input  1  synchronous active-high reset.
- en  input  1  clock enable; 0 holds all state.
- mode  input  3  operation select (encoding in Behaviour).
- d  input  n  parallel load data.
- sin  input  1  serial input for logical shifts.
- q  output  n  register contents.
- co  output  1  registered carry / borrow / bit shifted out.
- zero  output  1  combinational; 1 when q == 0.

Behaviour:
- Clock and reset:
  - One clock, clk. Reset is synchronous and active-high on rst.
  - Priority per posedge: rst, then en, then mode.
  - Reset: q <= RST_VAL, co <= 0. zero follows q, so zero = (RST_VAL == 0).
  - rst asserted mid-operation overrides any mode on that edge.
- Enable:
  - rst=0, en=0: q and co hold regardless of mode, d and sin.
- Modes (rst=0, en=1), single-cycle latency; the new q is visible after the same posedge:
  - 000 HOLD: q, co unchanged.
  - 001 LOAD: q <= d; co <= 0.
  - 010 SHL: q <= {q[n-2:0], sin}; co <= q[n-1].
  - 011 SHR: q <= {sin, q[n-1:1]}; co <= q[0].
  - 100 ROL: q <= {q[n-2:0], q[n-1]}; co <= q[n-1].
  - 101 ROR: q <= {q[0], q[n-1:1]}; co <= q[0].
  - 110 INC: {co, q} <= q + 1, computed n+1 bits wide. All-ones wraps to 0 with co=1; otherwise co=0.
  - 111 DEC: q <= q - 1 mod 2^n; co <= 1 only when q was 0 (borrow). 0 wraps to all-ones with co=1.
- Arithmetic and flags:
  - Unsigned modulo 2^n. No saturation.
  - co reflects only the most recent enabled non-HOLD operation.
  - zero is purely combinational from q. It has no added latency and glitches only with q.
- Mode changes take effect on the next edge. There is no internal state beyond q and co, so any mode sequence is legal back-to-back.
- No X propagation from sin is allowed in ROL, ROR, INC, DEC or LOAD. sin is used only in SHL and SHR.

Test Plan (n=8, RST_VAL=8'hA5 unless stated):
- Reset behaviour:
  - Stimulus: rst=1 for 2 cycles with en=1, mode=LOAD, d=8'h3C.
  - Required: q=8'hA5, co=0, zero=0. Then rst=0, LOAD d=8'h3C -> q=8'h3C, co=0 one cycle later.
- Enable and hold:
  - Stimulus: from q=8'h3C, en=0 for 4 cycles while mode cycles INC/SHL/LOAD with d=8'hFF.
  - Required: q stays 8'h3C, co stays 0. Then en=1, mode=HOLD for 2 cycles -> still 8'h3C.
- Shifts and rotates:
  - Stimulus: LOAD 8'h81, then in sequence SHL sin=0, SHR sin=1, ROL, ROR.
  - Required sequence: q=8'h02 co=1; then q=8'h81 co=0; then q=8'h03 co=1; then q=8'h81 co=1.
- Increment and decrement wrap:
  - Stimulus: LOAD 8'hFE, INC, INC, then DEC.
  - Required: after first INC q=8'hFF co=0; after second INC q=8'h00 co=1 zero=1; after DEC q=8'hFF co=1 zero=0. A further DEC gives q=8'hFE co=0.
- Reset mid-count:
  - Stimulus: RST_VAL=0, LOAD 8'h10, INC for 3 cycles, assert rst on the 4th edge with mode=INC.
  - Required: q=8'h13 before reset, then q=8'h00, co=0, zero=1. After release with INC, q=8'h01.
- Width parameter:
  - Stimulus: rerun the INC/DEC wrap scenario with n=2, RST_VAL=2'b11.
  - Required: reset gives q=3, INC gives q=0 co=1, DEC gives q=3 co=1.
  - Also with n=2: ROL on q=2'b10 gives q=2'b01 co=1.
